pwm_speed_ramp_ctrl: RTL and testbench
======================================

// Module: pwm_speed_ramp_ctrl
// PURPOSE
//  Sequences speed commands into the pwm_speed duty input (data_in).
//  Accepts target speeds over a valid/ready handshake and clamps them to the legal duty range.
//  Slews speed_out toward the target by at most STEP per PWM frame, updating only on frame boundaries.
//  An emergency-stop input forces zero drive immediately; the block sits between the command decoder and pwm_speed.
// PARAMETERS
//  FRAME_LEN  607  PWM frame length in clk cycles; must equal the pwm_speed counter period (0..606)
//  MAX_SPEED  199  largest legal speed code; pwm_speed treats codes >=200 as zero duty
//  STEP       4    max speed change per frame, 1..56 (keeps MAX_SPEED+STEP < 256)
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous, active-high reset
//  cmd_valid   in   1  cmd_speed is valid
//  cmd_ready   out  1  block can accept a command
//  cmd_speed   in   8  requested target speed code
//  estop       in   1  emergency stop, level-sensitive, already synchronous to clk
//  speed_out   out  8  registered speed code, drives pwm_speed data_in
//  frame_tick  out  1  one-cycle pulse on the last cycle of each frame
//  busy        out  1  high while ramping (state RAMP)
//  at_target   out  1  high when speed_out == target and state != ESTOP
// BEHAVIOUR
//  Reset (async, immediate):
//   - state=IDLE, speed_out=0, target=0, frame count=0
//   - frame_tick=0, busy=0, at_target=1, cmd_ready=1
//  Frame timer:
//   - 10-bit count runs 0..FRAME_LEN-1 and wraps to 0
//   - frame_tick = (count==FRAME_LEN-1), registered; it free-runs in every state
//  Handshake:
//   - Command accepted on the cycle cmd_valid && cmd_ready
//   - target <= min(cmd_speed, MAX_SPEED) on the next edge
//   - cmd_ready = (state != ESTOP) && !estop
//   - A new command in RAMP replaces target; ramping continues from the current speed_out
//  States (enum in package):
//   - IDLE: on accept with clamped value != speed_out -> RAMP; equal -> stay IDLE
//   - RAMP, on frame_tick: d = target - speed_out, computed as 9-bit signed
//     - |d| <= STEP: speed_out <= target, go to IDLE
//     - else speed_out <= speed_out +/- STEP (sign of d), stay in RAMP
//     - Between ticks speed_out holds
//   - ESTOP, entered from any state on the cycle after estop=1:
//     - speed_out <= 0 and target <= 0 at once, not frame-aligned
//     - cmd_valid is ignored; state holds while estop=1
//     - estop=0 -> IDLE with speed_out=0
//  Simultaneous events:
//   - Accept + frame_tick in RAMP: the step uses the old target; the new target latches the same edge
//   - estop beats everything, including a same-cycle accept (cmd_ready is already 0)
//  Arithmetic: all intermediate sums are 9 bits; speed_out never exceeds MAX_SPEED and never goes below 0.
//  Latency:
//   - accept -> first speed change at the next frame_tick after target latches (<= FRAME_LEN+1 cycles)
//   - estop -> speed_out=0 in 1 cycle
//  Reset mid-ramp: everything returns to reset values at once; the frame count restarts from 0.
// STRUCTURE
//  pwm_pkg:
//   - typedef enum logic [1:0] {IDLE, RAMP, ESTOP} ramp_state_t
//   - localparam PWM_FRAME_LEN=607, PWM_MAX_SPEED=199
//   - shared with pwm_speed
//  Sub-module pwm_frame_timer (FRAME_LEN): frame counter plus the registered frame_tick.
//   - Reusable to phase-align other PWM consumers.
//  Top level holds the FSM, target/speed registers, clamp and step logic.
// TESTING
//  1. Reset, then cmd 40 -> accepted in 1 cycle; speed_out 0,4,...,40 across 10 ticks; then IDLE, at_target=1, busy=0.
//  2. cmd 250 -> target clamps to 199; speed_out reaches 199 after 50 ticks (last step 3); never reads 200+.
//  3. At speed 100, cmd 10 -> ramps down 96,92,...,12, then 10 on tick 23; no underflow.
//  4. Mid-ramp at 60 toward 120, assert estop -> speed_out=0 next cycle, cmd_ready=0, cmd_valid ignored; release -> IDLE, speed 0.
//  5. Accept cmd 20 in the same cycle as frame_tick while ramping from 0 toward 100:
//     - that tick steps to 4 (old target)
//     - later ticks go 8,...,20, then IDLE
//  6. Assert rst mid-ramp at speed 52 -> immediately speed_out=0, cmd_ready=1, frame_tick=0; first tick 607 cycles after release.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: ramp FSM states, frame/speed limits and the speed clamp.
// Used by the ramp controller and by the pwm_speed consumer.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        ESTOP = 2'd2
    } ramp_state_t;

    localparam int PWM_FRAME_LEN = 607;
    localparam int PWM_MAX_SPEED = 199;

    function automatic logic [7:0] clamp_speed(input logic [7:0] speed, input logic [7:0] max_speed);
        return (speed > max_speed) ? max_speed : speed;
    endfunction

endpackage

// File: rtl/pwm_speed_ramp_ctrl_if.sv
// Speed command handshake between the command decoder (master) and the ramp controller (slave).
interface pwm_speed_ramp_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_speed;

    modport master (output cmd_valid, output cmd_speed, input cmd_ready);
    modport slave (input cmd_valid, input cmd_speed, output cmd_ready);
endinterface

// File: rtl/pwm_frame_timer.sv
// Free-running PWM frame counter with a registered end-of-frame pulse; lets any PWM
// consumer phase-align to the pwm_speed counter period.
module pwm_frame_timer
    import pwm_pkg::*;
#(
    parameter int FRAME_LEN = PWM_FRAME_LEN
) (
    input  logic clk,
    input  logic rst,
    output logic frame_tick
);

    localparam logic [9:0] LAST = 10'(FRAME_LEN - 1);

    logic [9:0] count;

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            frame_tick <= 1'b0;
        end else begin
            count      <= (count == LAST) ? '0 : count + 10'd1;
            frame_tick <= (count == LAST);
        end
    end

endmodule

// File: rtl/pwm_speed_ramp_ctrl.sv
// Speed command sequencer: clamps accepted targets, slews speed_out by at most STEP per
// PWM frame, and forces zero drive immediately on emergency stop.
module pwm_speed_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int FRAME_LEN = PWM_FRAME_LEN,
    parameter int MAX_SPEED = PWM_MAX_SPEED,
    parameter int STEP      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    pwm_speed_ramp_ctrl_if.slave        cmd,
    input  logic                        estop,
    output logic [7:0]                  speed_out,
    output logic                        frame_tick,
    output logic                        busy,
    output logic                        at_target
);

    localparam logic [7:0] MAX_CODE = 8'(MAX_SPEED);
    localparam logic [8:0] STEP_W   = 9'(STEP);

    ramp_state_t       state, state_nxt;
    logic [7:0]        target, target_nxt, speed_nxt;
    logic              accept;
    logic [7:0]        clamped;
    logic signed [8:0] diff;
    logic [8:0]        diff_mag;
    logic              step_done;

    pwm_frame_timer #(.FRAME_LEN(FRAME_LEN)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick)
    );

    assign cmd.cmd_ready = (state != ESTOP) && !estop;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign clamped       = clamp_speed(cmd.cmd_speed, MAX_CODE);

    // Both codes fit in 8 bits, so a 9-bit signed difference cannot overflow.
    assign diff      = $signed({1'b0, target}) - $signed({1'b0, speed_out});
    assign diff_mag  = diff[8] ? $unsigned(-diff) : $unsigned(diff);
    assign step_done = (diff_mag <= STEP_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            speed_out <= '0;
            target    <= '0;
        end else begin
            state     <= state_nxt;
            speed_out <= speed_nxt;
            target    <= target_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        speed_nxt  = speed_out;
        target_nxt = target;
        if (estop) begin
            state_nxt  = ESTOP;
            speed_nxt  = '0;
            target_nxt = '0;
        end else begin
            unique case (state)
                ESTOP: state_nxt = IDLE;
                RAMP: begin
                    if (frame_tick) begin
                        if (step_done) begin
                            speed_nxt = target;
                            state_nxt = IDLE;
                        end else if (diff[8]) begin
                            speed_nxt = 8'({1'b0, speed_out} - STEP_W);
                        end else begin
                            speed_nxt = 8'({1'b0, speed_out} + STEP_W);
                        end
                    end
                end
                default: ;
            endcase
            // The step above used the old target; a command on this edge retargets from the new speed.
            if (accept) begin
                target_nxt = clamped;
                if (clamped != speed_nxt) state_nxt = RAMP;
            end
        end
    end

    assign busy      = (state == RAMP);
    assign at_target = (speed_out == target) && (state != ESTOP);

endmodule

// File: tb/tb_pwm_speed_ramp_ctrl.sv
// Self-checking bench for pwm_speed_ramp_ctrl: directed ramp scenarios plus random
// commands/estops, every cycle compared against a frame-level behavioural model.
module tb_pwm_speed_ramp_ctrl;
    import pwm_pkg::*;

    localparam int FRAME_LEN = 607;
    localparam int MAX_SPEED = 199;
    localparam int STEP      = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       estop;
    logic [7:0] speed_out;
    logic       frame_tick, busy, at_target;

    pwm_speed_ramp_ctrl_if cmd_if ();

    pwm_speed_ramp_ctrl #(.FRAME_LEN(FRAME_LEN), .MAX_SPEED(MAX_SPEED), .STEP(STEP)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd_if),
        .estop      (estop),
        .speed_out  (speed_out),
        .frame_tick (frame_tick),
        .busy       (busy),
        .at_target  (at_target)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, actual, expected, $time);
        end
    endtask

    // Behavioural model: speed, target, ramping flag, stop flag and the frame position.
    int m_speed, m_target, m_count;
    bit m_ramp, m_stop, m_tick;

    function automatic void model_reset();
        m_speed = 0; m_target = 0; m_count = 0;
        m_ramp = 0; m_stop = 0; m_tick = 0;
    endfunction

    function automatic void model_edge(input bit valid, input int speed_cmd, input bit stop_in);
        bit tick_now = m_tick;
        bit accept   = valid && !m_stop && !stop_in;
        bit done     = 0;
        int d;
        m_tick  = (m_count == FRAME_LEN - 1);
        m_count = (m_count + 1) % FRAME_LEN;
        if (stop_in) begin
            m_stop = 1; m_speed = 0; m_target = 0; m_ramp = 0;
            return;
        end
        if (m_stop) begin
            m_stop = 0;
            return;
        end
        if (m_ramp && tick_now) begin
            d = m_target - m_speed;
            if (d <= STEP && d >= -STEP) begin
                m_speed = m_target;
                done    = 1;
            end else begin
                m_speed = m_speed + ((d > 0) ? STEP : -STEP);
            end
        end
        m_ramp = m_ramp && !done;
        if (accept) begin
            m_target = (speed_cmd > MAX_SPEED) ? MAX_SPEED : speed_cmd;
            m_ramp   = m_ramp || (m_target != m_speed);
        end
    endfunction

    int seen[$];
    int prev_speed = 0;
    int max_seen   = 0;

    // One clock: model follows the edge, DUT is compared on the falling edge.
    task automatic cycle();
        logic [11:0] exp_status, act_status;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(cmd_if.cmd_valid, int'(cmd_if.cmd_speed), estop);
        @(negedge clk);
        exp_status = {8'(m_speed), !m_stop && !estop, m_ramp, (m_speed == m_target) && !m_stop, m_tick};
        act_status = {speed_out, cmd_if.cmd_ready, busy, at_target, frame_tick};
        check("status{speed,ready,busy,at,tick}", 32'(act_status), 32'(exp_status));
        if (int'(speed_out) != prev_speed) seen.push_back(int'(speed_out));
        prev_speed = int'(speed_out);
        if (int'(speed_out) > max_seen) max_seen = int'(speed_out);
    endtask

    task automatic send_cmd(input int value);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_speed = 8'(value);
        check("cmd_ready_at_accept", 32'(cmd_if.cmd_ready), 32'd1);
        cycle();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while (busy && n < bound) begin
            cycle();
            n++;
        end
        check({tag, "_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_speed(input string tag, input int value, input int bound);
        int n = 0;
        while (int'(speed_out) != value && n < bound) begin
            cycle();
            n++;
        end
        check(tag, 32'(speed_out), 32'(value));
    endtask

    // Expected per-frame speed sequence from the slew rule, compared to the observed changes.
    task automatic expect_ramp(input string tag, input int from, input int to);
        int exp_q[$];
        int s = from;
        int n;
        while (s != to) begin
            if (to - s <= STEP && to - s >= -STEP) s = to;
            else s = s + ((to > s) ? STEP : -STEP);
            exp_q.push_back(s);
        end
        check({tag, "_len"}, 32'(seen.size()), 32'(exp_q.size()));
        n = (seen.size() < exp_q.size()) ? seen.size() : exp_q.size();
        for (int i = 0; i < n; i++) check(tag, 32'(seen[i]), 32'(exp_q[i]));
        seen.delete();
    endtask

    initial begin
        int n;
        int hold;
        rst = 1'b1; estop = 1'b0;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_speed = '0;
        model_reset();
        cycle();
        cycle();
        check("rst_speed", 32'(speed_out), 32'd0);
        check("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
        check("rst_tick", 32'(frame_tick), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_at_target", 32'(at_target), 32'd1);
        rst = 1'b0;
        seen.delete();

        // Ramp 0 -> 40 in ten frames.
        send_cmd(40);
        check("ramp40_busy", 32'(busy), 32'd1);
        wait_idle("ramp40", 12 * FRAME_LEN);
        expect_ramp("ramp40_seq", 0, 40);
        check("ramp40_at_target", 32'(at_target), 32'd1);

        // Estop mid-ramp at 60 toward 120; commands ignored while stopped.
        send_cmd(120);
        wait_speed("estop_reach60", 60, 8 * FRAME_LEN);
        estop = 1'b1;
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_speed = 8'd77;
        cycle();
        check("estop_speed", 32'(speed_out), 32'd0);
        check("estop_ready", 32'(cmd_if.cmd_ready), 32'd0);
        check("estop_at_target", 32'(at_target), 32'd0);
        repeat (5) cycle();
        estop = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cycle();
        check("estop_release_speed", 32'(speed_out), 32'd0);
        check("estop_release_busy", 32'(busy), 32'd0);
        check("estop_release_at_target", 32'(at_target), 32'd1);
        seen.delete();

        // Clamp: 250 -> 199 in 50 frames, last step 3.
        send_cmd(250);
        wait_idle("clamp", 52 * FRAME_LEN);
        expect_ramp("clamp_seq", 0, 199);
        check("clamp_max_seen", 32'(max_seen), 32'd199);

        // Ramp down 199 -> 10 with no underflow.
        send_cmd(10);
        wait_idle("down", 50 * FRAME_LEN);
        expect_ramp("down_seq", 199, 10);
        check("down_final", 32'(speed_out), 32'd10);

        // Retarget on the same cycle as frame_tick: step uses the old target.
        estop = 1'b1;
        cycle();
        estop = 1'b0;
        cycle();
        seen.delete();
        send_cmd(100);
        n = 0;
        while (!frame_tick && n < FRAME_LEN + 2) begin
            cycle();
            n++;
        end
        check("sametick_found", 32'(frame_tick), 32'd1);
        send_cmd(20);
        check("sametick_step", 32'(speed_out), 32'd4);
        wait_idle("sametick", 8 * FRAME_LEN);
        expect_ramp("sametick_seq", 0, 20);

        // Reset mid-ramp at 52, then first tick one full frame after release.
        send_cmd(120);
        wait_speed("rst_reach52", 52, 10 * FRAME_LEN);
        rst = 1'b1;
        #1;
        check("midrst_speed", 32'(speed_out), 32'd0);
        check("midrst_ready", 32'(cmd_if.cmd_ready), 32'd1);
        check("midrst_tick", 32'(frame_tick), 32'd0);
        model_reset();
        cycle();
        rst = 1'b0;
        n = 0;
        while (n < FRAME_LEN + 5) begin
            cycle();
            n++;
            if (frame_tick) break;
        end
        check("first_tick_cycles", 32'(n), 32'(FRAME_LEN));
        seen.delete();

        // Random commands and estop bursts against the model.
        hold = 0;
        repeat (6000) begin
            cmd_if.cmd_valid = ($urandom_range(0, 99) < 3);
            cmd_if.cmd_speed = 8'($urandom_range(0, 255));
            if (hold > 0) hold--;
            else if ($urandom_range(0, 999) < 3) hold = $urandom_range(1, 6);
            estop = (hold > 0);
            cycle();
        end
        cmd_if.cmd_valid = 1'b0;
        estop = 1'b0;
        cycle();
        check("random_max_speed", 32'(max_seen), 32'd199);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
